// File: rtl/sram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// sram_fifo_ctrl_if : push/pop streams, status and SRAM port of sram_fifo_ctrl
// Revision: 1.0
// ============================================================================
interface sram_fifo_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              push_valid;
  logic              push_ready;
  logic [DATA_W-1:0] push_data;
  logic              pop_valid;
  logic              pop_ready;
  logic [DATA_W-1:0] pop_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_we;
  logic [DATA_W-1:0] mem_data_out;

  // master: surrounding datapath plus SRAM; slave: the controller
  modport master (
    output push_valid, push_data, pop_ready, mem_data_out,
    input  push_ready, pop_valid, pop_data, count, full, empty,
           mem_addr, mem_data_in, mem_we
  );

  modport slave (
    input  push_valid, push_data, pop_ready, mem_data_out,
    output push_ready, pop_valid, pop_data, count, full, empty,
           mem_addr, mem_data_in, mem_we
  );
endinterface
`default_nettype wire

// File: rtl/sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// sram_fifo_ctrl : FIFO over one single-port SRAM, round-robin push/pop port
// Revision: 1.0
// ============================================================================
module sram_fifo_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  sram_fifo_ctrl_if.slave     bus
);

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_cnt_q, mem_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              rr_q, rr_d;

  logic              mem_full;
  logic              rd_req;
  logic              wr_req;
  logic              wr_gnt;
  logic              rd_gnt;
  logic [ADDR_W:0]   count;

  assign mem_full = (mem_cnt_q == DEPTH_CNT);
  assign rd_req   = (mem_cnt_q != '0) && (!out_valid_q || bus.pop_ready);
  assign wr_req   = bus.push_valid && !mem_full;
  // rst_n gates the write so reset cycles never touch the SRAM
  assign wr_gnt   = rst_n && wr_req && (!rd_req || !rr_q);
  assign rd_gnt   = rd_req && (!wr_req || rr_q);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_d        = rr_q;
    if (wr_gnt) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      mem_cnt_d = mem_cnt_q + 1'b1;
    end
    if (rd_gnt) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      mem_cnt_d   = mem_cnt_q - 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = bus.mem_data_out;
    end else if (out_valid_q && bus.pop_ready) begin
      out_valid_d = 1'b0;
    end
    if (wr_req && rd_req) begin
      rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_q        <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_q        <= rr_d;
    end
  end

  assign count           = mem_cnt_q + {{ADDR_W{1'b0}}, out_valid_q};
  assign bus.count       = count;
  assign bus.full        = mem_full;
  assign bus.empty       = (count == '0);
  assign bus.push_ready  = rst_n && !mem_full && !(rd_req && rr_q);
  assign bus.pop_valid   = out_valid_q;
  assign bus.pop_data    = out_data_q;
  assign bus.mem_we      = wr_gnt;
  assign bus.mem_addr    = wr_gnt ? wr_ptr_q : rd_ptr_q;
  assign bus.mem_data_in = bus.push_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
`default_nettype none
// Bench for sram_fifo_ctrl: vector table, corner sequences and a random
// stream checked against a queue-based reference model.
module tb_sram_fifo_ctrl;
  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 512;

  logic clk = 1'b0;
  logic rst_n;
  logic [DW-1:0] sram [DEPTH];

  sram_fifo_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_data_in;
  assign bus.mem_data_out = sram[bus.mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: FIFO contents as a queue, plus output register and arbiter bit
  logic [7:0] q[$];
  bit         m_ov;
  logic [7:0] m_od;
  bit         m_rr;
  int         m_wp, m_rp;
  int         d_max;

  bit         push_fire, pop_fire;
  logic [7:0] pop_val;

  typedef struct {
    bit r; bit pv; logic [7:0] pd; bit pr;
    bit e_prdy; bit e_we; logic [8:0] e_addr; bit e_pv;
    logic [7:0] e_pdata; logic [9:0] e_cnt; bit e_full; bit e_empty;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.push_valid = 1'b0; bus.pop_ready = 1'b0;
    @(posedge clk);
    q.delete(); m_ov = 1'b0; m_od = '0; m_rr = 1'b0; m_wp = 0; m_rp = 0; d_max = 0;
  endtask

  task automatic cycle(input bit r, input bit pv, input logic [7:0] pd, input bit pr);
    int mcnt;
    bit rd_req, wr_req, gw, gr;
    @(negedge clk);
    rst_n = r; bus.push_valid = pv; bus.push_data = pd; bus.pop_ready = pr;
    #2;
    mcnt   = q.size();
    rd_req = (mcnt != 0) && (!m_ov || pr);
    wr_req = pv && (mcnt != DEPTH);
    gw     = r && wr_req && (!rd_req || !m_rr);
    gr     = rd_req && (!wr_req || m_rr);
    check("push_ready", 32'(bus.push_ready), 32'(r && mcnt != DEPTH && !(rd_req && m_rr)));
    check("mem_we", 32'(bus.mem_we), 32'(gw));
    check("mem_addr", 32'(bus.mem_addr), gw ? m_wp : m_rp);
    if (gw) check("mem_data_in", 32'(bus.mem_data_in), 32'(pd));
    check("pop_valid", 32'(bus.pop_valid), 32'(m_ov));
    check("pop_data", 32'(bus.pop_data), 32'(m_od));
    check("count", 32'(bus.count), mcnt + int'(m_ov));
    check("full", 32'(bus.full), 32'(mcnt == DEPTH));
    check("empty", 32'(bus.empty), 32'((mcnt + int'(m_ov)) == 0));
    if (int'(bus.count) > d_max) d_max = int'(bus.count);
    push_fire = pv && bus.push_ready;
    pop_fire  = bus.pop_valid && pr;
    pop_val   = bus.pop_data;
    @(posedge clk);
    if (!r) begin
      q.delete(); m_ov = 1'b0; m_od = '0; m_rr = 1'b0; m_wp = 0; m_rp = 0;
    end else begin
      if (gw) begin q.push_back(pd); m_wp = (m_wp + 1) % DEPTH; end
      if (gr) begin m_od = q.pop_front(); m_ov = 1'b1; m_rp = (m_rp + 1) % DEPTH; end
      else if (m_ov && pr) m_ov = 1'b0;
      if (wr_req && rd_req) m_rr = !m_rr;
    end
  endtask

  initial begin
    int acc, npush, npop, cyc;
    bit pv, pr;

    //            r     pv    pd     pr     prdy  we    addr   pv    pdata  cnt     full  empty
    tbl[0] = '{1'b0, 1'b1, 8'h77, 1'b0,  1'b0, 1'b0, 9'd0, 1'b0, 8'h00, 10'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 8'h88, 1'b0,  1'b0, 1'b0, 9'd0, 1'b0, 8'h00, 10'd0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'hA5, 1'b1,  1'b1, 1'b1, 9'd0, 1'b0, 8'h00, 10'd0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 9'd0, 1'b0, 8'h00, 10'd1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 9'd1, 1'b1, 8'hA5, 10'd1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 9'd1, 1'b0, 8'hA5, 10'd0, 1'b0, 1'b1};

    rst_n = 1'b0; bus.push_valid = 1'b0; bus.push_data = '0; bus.pop_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset with push_valid held, then a single word end to end
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].r; bus.push_valid = tbl[i].pv;
      bus.push_data = tbl[i].pd; bus.pop_ready = tbl[i].pr;
      #2;
      check($sformatf("v%0d.push_ready", i), 32'(bus.push_ready), 32'(tbl[i].e_prdy));
      check($sformatf("v%0d.mem_we", i), 32'(bus.mem_we), 32'(tbl[i].e_we));
      check($sformatf("v%0d.mem_addr", i), 32'(bus.mem_addr), 32'(tbl[i].e_addr));
      check($sformatf("v%0d.pop_valid", i), 32'(bus.pop_valid), 32'(tbl[i].e_pv));
      check($sformatf("v%0d.pop_data", i), 32'(bus.pop_data), 32'(tbl[i].e_pdata));
      check($sformatf("v%0d.count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
      check($sformatf("v%0d.full", i), 32'(bus.full), 32'(tbl[i].e_full));
      check($sformatf("v%0d.empty", i), 32'(bus.empty), 32'(tbl[i].e_empty));
      @(posedge clk);
    end

    // fill to DEPTH+1 words, then drain in order
    hard_reset();
    acc = 0;
    for (int i = 0; i < 514; i++) begin
      cycle(1'b1, 1'b1, 8'(acc), 1'b0);
      if (push_fire) acc++;
    end
    #1;
    check("fill_accepted", acc, 513);
    check("fill_count", 32'(bus.count), 513);
    check("fill_full", 32'(bus.full), 1);
    check("fill_push_ready", 32'(bus.push_ready), 0);
    npop = 0;
    for (cyc = 0; cyc < 2000 && npop < 513; cyc++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      if (pop_fire) begin check("fill_order", 32'(pop_val), npop & 255); npop++; end
    end
    check("fill_popped", npop, 513);
    @(negedge clk); #1;
    check("fill_empty", 32'(bus.empty), 1);

    // contention: alternate write/read under saturated push and pop
    hard_reset();
    acc = 0;
    for (cyc = 0; cyc < 20 && acc < 4; cyc++) begin
      cycle(1'b1, 1'b1, 8'(acc), 1'b0);
      if (push_fire) acc++;
    end
    npush = 0; npop = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 8'(acc), 1'b1);
      if (push_fire) begin acc++; npush++; end
      if (pop_fire) begin check("cont_order", 32'(pop_val), npop & 255); npop++; end
    end
    check("cont_pushes", npush, 10);
    check("cont_pops", npop, 10);

    // random stream long enough to wrap the pointers several times
    hard_reset();
    npush = 0; npop = 0;
    for (cyc = 0; cyc < 30000 && npop < 1500; cyc++) begin
      pv = (npush < 1500) && ($urandom_range(0, 3) != 0);
      pr = ($urandom_range(0, 2) != 0);
      cycle(1'b1, pv, 8'(npush), pr);
      if (push_fire) npush++;
      if (pop_fire) begin check("wrap_order", 32'(pop_val), npop & 255); npop++; end
    end
    check("wrap_popped", npop, 1500);
    check("wrap_max_count_le_513", 32'(d_max <= 513), 1);

    // reset in the middle of an active push discards everything
    hard_reset();
    acc = 0;
    for (cyc = 0; cyc < 100 && (q.size() + int'(m_ov)) != 37; cyc++) begin
      cycle(1'b1, 1'b1, 8'(acc), 1'b0);
      if (push_fire) acc++;
    end
    #1;
    check("mid_count_before", 32'(bus.count), 37);
    cycle(1'b0, 1'b1, 8'hEE, 1'b0);
    #1;
    check("mid_count_after", 32'(bus.count), 0);
    check("mid_pop_valid_after", 32'(bus.pop_valid), 0);
    acc = 0;
    for (cyc = 0; cyc < 5 && acc == 0; cyc++) begin
      cycle(1'b1, 1'b1, 8'h3C, 1'b0);
      if (push_fire) acc = 1;
    end
    npop = 0;
    for (cyc = 0; cyc < 10 && npop == 0; cyc++) begin
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      if (pop_fire) begin check("mid_first_pop", 32'(pop_val), 32'h3C); npop = 1; end
    end
    check("mid_popped", npop, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
